// File: rtl/mw_fwd_sel_reg_if.sv
// M-stage forward / W-stage write-back bundle between the pipeline control and mw_fwd_sel_reg.
// master drives the M-stage side, slave is the forwarding/W-register block.
interface mw_fwd_sel_reg_if #(
   parameter int unsigned DW   = 32,
   parameter int unsigned NSRC = 4,
   parameter int unsigned SELW = 3
);
   logic [NSRC*DW-1:0] m_src;
   logic [31:0]        m_pc;
   logic [SELW-1:0]    m_sel;
   logic [4:0]         m_rd;
   logic               m_we;
   logic               m_valid;
   logic               md_busy;
   logic               stall;
   logic               flush;
   logic [DW-1:0]      w_late;

   logic [DW-1:0]      m_fwd_data;
   logic               m_fwd_ok;
   logic               stall_req;
   logic [DW-1:0]      w_data;
   logic [4:0]         w_rd;
   logic               w_we;
   logic               w_valid;

   modport master (
      output m_src, m_pc, m_sel, m_rd, m_we, m_valid, md_busy, stall, flush, w_late,
      input  m_fwd_data, m_fwd_ok, stall_req, w_data, w_rd, w_we, w_valid
   );

   modport slave (
      input  m_src, m_pc, m_sel, m_rd, m_we, m_valid, md_busy, stall, flush, w_late,
      output m_fwd_data, m_fwd_ok, stall_req, w_data, w_rd, w_we, w_valid
   );
endinterface

// File: rtl/mw_fwd_sel_reg.sv
// M-stage write-back source select with forwarding, plus the M->W pipeline register.
// Late (load) data is merged at the W output; mult/div results hold the instruction in M.
module mw_fwd_sel_reg #(
   parameter int unsigned DW       = 32,
   parameter int unsigned NSRC     = 4,
   parameter int unsigned SELW     = 3,
   parameter int unsigned PC_SEL   = 2,
   parameter int unsigned PC_OFS   = 8,
   parameter int unsigned MD_SEL   = 3,
   parameter int unsigned LATE_SEL = 1
) (
   input  logic                clk,
   input  logic                reset,
   mw_fwd_sel_reg_if.slave     bus
);
   localparam int unsigned RDW = 5;

   logic [31:0]     pc_link;
   logic [DW-1:0]   fwd_data;
   logic            is_md;
   logic            is_late;
   logic            md_hold;
   logic            fwd_ok;

   logic [DW-1:0]   data_q,  data_d;
   logic [SELW-1:0] sel_q,   sel_d;
   logic [RDW-1:0]  rd_q,    rd_d;
   logic            we_q,    we_d;
   logic            valid_q, valid_d;

   // Source mux; codes at or beyond NSRC forward zero, the PC slot is replaced by the link address
   always_comb begin
      pc_link  = bus.m_pc + 32'(PC_OFS);
      fwd_data = '0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (bus.m_sel == SELW'(i)) fwd_data = bus.m_src[i*DW +: DW];
      end
      if (bus.m_sel == SELW'(PC_SEL)) fwd_data = DW'(pc_link);
   end

   always_comb begin
      is_md   = (bus.m_sel == SELW'(MD_SEL));
      is_late = (bus.m_sel == SELW'(LATE_SEL));
      md_hold = bus.m_valid & is_md & bus.md_busy;
      fwd_ok  = bus.m_valid & bus.m_we & (bus.m_rd != '0) & ~is_late & ~(is_md & bus.md_busy);
   end

   assign bus.m_fwd_data = fwd_data;
   assign bus.m_fwd_ok   = fwd_ok;
   assign bus.stall_req  = md_hold;

   // W next state: flush beats stall beats the mult/div hold beats a normal load
   always_comb begin
      data_d  = data_q;
      sel_d   = sel_q;
      rd_d    = rd_q;
      we_d    = we_q;
      valid_d = valid_q;
      if (bus.flush || (!bus.stall && md_hold)) begin
         data_d  = '0;
         sel_d   = '0;
         rd_d    = '0;
         we_d    = 1'b0;
         valid_d = 1'b0;
      end else if (!bus.stall) begin
         data_d  = is_late ? '0 : fwd_data;
         sel_d   = bus.m_sel;
         rd_d    = bus.m_rd;
         we_d    = bus.m_we;
         valid_d = bus.m_valid;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q  <= '0;
         sel_q   <= '0;
         rd_q    <= '0;
         we_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         sel_q   <= sel_d;
         rd_q    <= rd_d;
         we_q    <= we_d;
         valid_q <= valid_d;
      end
   end

   // Load data only exists in W, so it bypasses the register here
   assign bus.w_data  = (sel_q == SELW'(LATE_SEL)) ? bus.w_late : data_q;
   assign bus.w_rd    = rd_q;
   assign bus.w_we    = we_q & valid_q & (rd_q != '0);
   assign bus.w_valid = valid_q;
endmodule

// File: tb/tb_mw_fwd_sel_reg.sv
// Randomized and directed check of mw_fwd_sel_reg against a behavioural pipeline model.
module tb_mw_fwd_sel_reg;
   localparam int DW = 32, NSRC = 4, SELW = 3;
   localparam int PC_SEL = 2, PC_OFS = 8, MD_SEL = 3, LATE_SEL = 1;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [31:0] src [NSRC];

   // Expected W contents
   bit          e_valid, e_we;
   int          e_rd, e_sel;
   logic [31:0] e_data;

   mw_fwd_sel_reg_if #(.DW(DW), .NSRC(NSRC), .SELW(SELW)) bus_if ();

   mw_fwd_sel_reg #(
      .DW(DW), .NSRC(NSRC), .SELW(SELW), .PC_SEL(PC_SEL), .PC_OFS(PC_OFS),
      .MD_SEL(MD_SEL), .LATE_SEL(LATE_SEL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_fwd();
      int s = int'(bus_if.m_sel);
      if (s == PC_SEL) return bus_if.m_pc + 32'(PC_OFS);
      if (s < NSRC) return src[s];
      return 32'h0;
   endfunction

   function automatic bit ref_busy();
      return bus_if.m_valid && int'(bus_if.m_sel) == MD_SEL && bus_if.md_busy;
   endfunction

   function automatic bit ref_ok();
      return bus_if.m_valid && bus_if.m_we && bus_if.m_rd != 0 &&
             int'(bus_if.m_sel) != LATE_SEL && !(int'(bus_if.m_sel) == MD_SEL && bus_if.md_busy);
   endfunction

   task automatic model_bubble();
      e_valid = 0; e_we = 0; e_rd = 0; e_sel = 0; e_data = 0;
   endtask

   task automatic check_w();
      check("w_valid", 64'(bus_if.w_valid), 64'(e_valid));
      check("w_we",    64'(bus_if.w_we),    64'(e_we && e_valid && e_rd != 0));
      check("w_rd",    64'(bus_if.w_rd),    64'(e_rd));
      check("w_data",  64'(bus_if.w_data),  64'((e_sel == LATE_SEL) ? bus_if.w_late : e_data));
   endtask

   task automatic pack_src();
      for (int i = 0; i < NSRC; i++) bus_if.m_src[i*DW +: DW] = src[i];
   endtask

   // One clock: check M-side outputs mid-cycle, advance the model at the edge, check W after it
   task automatic run_cycle();
      bit          nb, nv, nw;
      int          nr, ns;
      logic [31:0] nd;
      pack_src();
      @(negedge clk);
      check("m_fwd_data", 64'(bus_if.m_fwd_data), 64'(ref_fwd()));
      check("m_fwd_ok",   64'(bus_if.m_fwd_ok),   64'(ref_ok()));
      check("stall_req",  64'(bus_if.stall_req),  64'(ref_busy()));
      nb = bus_if.flush || (!bus_if.stall && ref_busy());
      nv = e_valid; nw = e_we; nr = e_rd; ns = e_sel; nd = e_data;
      if (!nb && !bus_if.stall) begin
         nv = bus_if.m_valid; nw = bus_if.m_we; nr = int'(bus_if.m_rd);
         ns = int'(bus_if.m_sel);
         nd = (ns == LATE_SEL) ? 32'h0 : ref_fwd();
      end
      @(posedge clk);
      #1;
      if (nb) model_bubble();
      else begin
         e_valid = nv; e_we = nw; e_rd = nr; e_sel = ns; e_data = nd;
      end
      check_w();
   endtask

   // Asynchronous reset pulse between edges; W must drop at once and stay empty after release
   task automatic reset_pulse();
      reset = 1'b0;
      #1;
      model_bubble();
      check("rst_w_valid", 64'(bus_if.w_valid), 64'(0));
      check("rst_w_we",    64'(bus_if.w_we),    64'(0));
      reset = 1'b1;
      #1;
      check("rel_w_valid", 64'(bus_if.w_valid), 64'(0));
      check_w();
   endtask

   task automatic set_m(input int sel, input int rd, input bit we, input bit valid);
      bus_if.m_sel = SELW'(sel); bus_if.m_rd = 5'(rd); bus_if.m_we = we; bus_if.m_valid = valid;
   endtask

   initial begin
      reset = 1'b0;
      for (int i = 0; i < NSRC; i++) src[i] = 32'h0;
      bus_if.m_src = '0; bus_if.m_pc = '0; bus_if.md_busy = 0;
      bus_if.stall = 0; bus_if.flush = 0; bus_if.w_late = '0;
      set_m(0, 0, 0, 0);
      model_bubble();
      #1;
      check_w();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Link address forward
      set_m(PC_SEL, 31, 1, 1); bus_if.m_pc = 32'h0000_3000;
      run_cycle();
      check("pc_wdata", 64'(bus_if.w_data), 64'h3008);
      check("pc_wrd",   64'(bus_if.w_rd),   64'd31);
      check("pc_wwe",   64'(bus_if.w_we),   64'd1);

      // Load data arrives only in W
      set_m(LATE_SEL, 5, 1, 1); bus_if.w_late = 32'hDEAD_BEEF;
      run_cycle();
      check("late_wdata", 64'(bus_if.w_data), 64'hDEAD_BEEF);
      check("late_wwe",   64'(bus_if.w_we),   64'd1);

      // Mult/div busy for three cycles
      set_m(MD_SEL, 9, 1, 1); src[MD_SEL] = 32'h1234_5678; bus_if.md_busy = 1;
      for (int i = 0; i < 3; i++) begin
         run_cycle();
         check("md_bubble", 64'(bus_if.w_valid), 64'd0);
      end
      bus_if.md_busy = 0;
      run_cycle();
      check("md_wdata", 64'(bus_if.w_data), 64'h1234_5678);

      // Flush beats stall
      set_m(0, 7, 1, 1); src[0] = 32'hA5A5_0001;
      run_cycle();
      bus_if.stall = 1; bus_if.flush = 1;
      run_cycle();
      check("flush_over_stall", 64'(bus_if.w_valid), 64'd0);
      bus_if.stall = 0; bus_if.flush = 0;

      // Writes to x0 never enable
      set_m(0, 0, 1, 1); src[0] = 32'hFFFF_FFFF;
      run_cycle();
      check("x0_wwe", 64'(bus_if.w_we), 64'd0);

      // Reset between edges with a valid W and mid-stall
      set_m(0, 12, 1, 1);
      run_cycle();
      bus_if.stall = 1;
      run_cycle();
      reset_pulse();
      run_cycle();
      bus_if.stall = 0;

      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NSRC; i++) src[i] = $urandom;
         bus_if.m_pc    = $urandom;
         bus_if.w_late  = $urandom;
         set_m(int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 31)),
               bit'($urandom_range(0, 1)), $urandom_range(0, 7) != 0);
         bus_if.md_busy = $urandom_range(0, 2) == 0;
         bus_if.stall   = $urandom_range(0, 7) == 0;
         bus_if.flush   = $urandom_range(0, 15) == 0;
         run_cycle();
         if ($urandom_range(0, 49) == 0) reset_pulse();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
